shape_compute_area: RTL and testbench



---
 rtl/shape_compute_area.sv | 144 ++++++++++++++
 tb/tb_shape_compute_area.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/shape_compute_area.sv
// Compound-area sink: captures one record of NUM_ELEMS dimension words and sums
// width*height over consecutive element pairs, one multiply-accumulate per clock.
// Optional area_degenerate output is enabled by defining SHAPE_AREA_DEGENERATE_EN.
module shape_compute_area #(
   parameter  int NUM_ELEMS = 4,
   parameter  int ELEM_W    = 39,
   localparam int AREA_W    = 2*ELEM_W + $clog2(NUM_ELEMS/2)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          shape_in_valid,
   output logic                          shape_in_ready,
   input  logic [NUM_ELEMS*ELEM_W-1:0]   shape_in_data,
   output logic [AREA_W-1:0]             area,
   output logic                          area_valid,
   input  logic                          area_ready
`ifdef SHAPE_AREA_DEGENERATE_EN
   ,
   output logic                          area_degenerate
`endif
);

   // state | meaning
   // IDLE  | waiting for a record; shape_in_ready high
   // CALC  | one pair product accumulated per clock
   // DONE  | result held until area_ready is sampled high

   localparam int NPAIR = NUM_ELEMS/2;
   localparam int IDX_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 capture;
   logic                 step;
   logic                 finish;
   logic                 res_taken;

   logic [ELEM_W-1:0]    elem_a [NPAIR];
   logic [ELEM_W-1:0]    elem_b [NPAIR];
   logic [IDX_W-1:0]     idx;
   logic [AREA_W-1:0]    acc;
   logic [AREA_W-1:0]    acc_sum;
   logic [2*ELEM_W-1:0]  prod;
   logic                 deg_acc;
   logic                 deg_sum;

   assign shape_in_ready = (state == IDLE) && rstn;

   // Operands are widened before the multiply so the full product is kept.
   assign prod    = {{ELEM_W{1'b0}}, elem_a[idx]} * {{ELEM_W{1'b0}}, elem_b[idx]};
   assign acc_sum = acc + AREA_W'(prod);
   assign deg_sum = deg_acc | (prod == '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      res_taken  = 1'b0;
      case (state)
         IDLE: begin
            if (shape_in_valid) begin
               capture    = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (idx == IDX_W'(NPAIR-1)) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (area_ready) begin
               res_taken  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int p = 0; p < NPAIR; p++) begin
            elem_a[p] <= '0;
            elem_b[p] <= '0;
         end
         idx        <= '0;
         acc        <= '0;
         deg_acc    <= 1'b0;
         area       <= '0;
         area_valid <= 1'b0;
      end else begin
         if (capture) begin
            for (int p = 0; p < NPAIR; p++) begin
               elem_a[p] <= shape_in_data[(2*p)*ELEM_W   +: ELEM_W];
               elem_b[p] <= shape_in_data[(2*p+1)*ELEM_W +: ELEM_W];
            end
            idx     <= '0;
            acc     <= '0;
            deg_acc <= 1'b0;
         end
         if (step) begin
            acc     <= acc_sum;
            deg_acc <= deg_sum;
            idx     <= idx + IDX_W'(1);
         end
         if (finish) begin
            area       <= acc_sum;
            area_valid <= 1'b1;
         end
         if (res_taken) begin
            area_valid <= 1'b0;
         end
      end
   end

`ifdef SHAPE_AREA_DEGENERATE_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         area_degenerate <= 1'b0;
      end else if (finish) begin
         area_degenerate <= deg_sum;
      end
   end
`endif

endmodule

// File: tb/tb_shape_compute_area.sv
// Randomized self-checking bench for shape_compute_area against a pairwise-sum
// reference model; also covers the directed cases (basic, sparse, max, backpressure, reset).
module tb_shape_compute_area;

   localparam int NE = 4;
   localparam int EW = 39;
   localparam int NP = NE/2;
   localparam int AW = 2*EW + $clog2(NE/2);

   logic              clk;
   logic              rstn;
   logic              shape_in_valid;
   logic              shape_in_ready;
   logic [NE*EW-1:0]  shape_in_data;
   logic [AW-1:0]     area;
   logic              area_valid;
   logic              area_ready;
`ifdef SHAPE_AREA_DEGENERATE_EN
   logic              area_degenerate;
`endif

   int n_total = 0;
   int n_bad   = 0;

   shape_compute_area #(.NUM_ELEMS(NE), .ELEM_W(EW)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .shape_in_valid (shape_in_valid),
      .shape_in_ready (shape_in_ready),
      .shape_in_data  (shape_in_data),
      .area           (area),
      .area_valid     (area_valid),
      .area_ready     (area_ready)
`ifdef SHAPE_AREA_DEGENERATE_EN
      ,
      .area_degenerate(area_degenerate)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NE*EW-1:0] pack4(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                                             input logic [EW-1:0] e2, input logic [EW-1:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   // Reference: plain sum of width*height over element pairs.
   function automatic logic [AW-1:0] ref_area(input logic [NE*EW-1:0] d);
      logic [AW-1:0] s;
      s = '0;
      for (int p = 0; p < NP; p++)
         s = s + AW'(d[(2*p)*EW +: EW]) * AW'(d[(2*p+1)*EW +: EW]);
      return s;
   endfunction

   function automatic logic ref_deg(input logic [NE*EW-1:0] d);
      logic r;
      r = 1'b0;
      for (int p = 0; p < NP; p++)
         if (AW'(d[(2*p)*EW +: EW]) * AW'(d[(2*p+1)*EW +: EW]) == '0) r = 1'b1;
      return r;
   endfunction

   function automatic logic [EW-1:0] rand_elem();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return EW'($urandom_range(0, 20));
         default: return r[EW-1:0];
      endcase
   endfunction

   // Offers one record, checks latency and result, holds area_ready low for
   // 'hold' cycles, then completes the handshake.
   task automatic send(input logic [NE*EW-1:0] d, input logic [AW-1:0] exp,
                       input int hold, input bit keep_valid, input logic [NE*EW-1:0] next_d);
      int n;
      int lat;
      area_ready     = (hold == 0);
      shape_in_data  = d;
      shape_in_valid = 1'b1;
      n = 0;
      while (!shape_in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check_eq("accept_wait", AW'(n < 50), AW'(1));
      @(posedge clk); #1;
      if (keep_valid) shape_in_data = next_d;
      else            shape_in_valid = 1'b0;
      lat = 0;
      while (!area_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      check_eq("latency", AW'(lat), AW'(NP));
      check_eq("area", area, exp);
      check_eq("in_ready_busy", AW'(shape_in_ready), AW'(0));
`ifdef SHAPE_AREA_DEGENERATE_EN
      check_eq("degenerate", AW'(area_degenerate), AW'(ref_deg(d)));
`endif
      for (int i = 0; i < hold; i++) begin
         if (!keep_valid) begin
            shape_in_valid = 1'b1;
            shape_in_data  = pack4(rand_elem(), rand_elem(), rand_elem(), rand_elem());
         end
         @(posedge clk); #1;
         check_eq("hold_area", area, exp);
         check_eq("hold_valid", AW'(area_valid), AW'(1));
         check_eq("hold_in_ready", AW'(shape_in_ready), AW'(0));
      end
      if (!keep_valid) shape_in_valid = 1'b0;
      area_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("valid_cleared", AW'(area_valid), AW'(0));
      check_eq("in_ready_again", AW'(shape_in_ready), AW'(1));
      check_eq("area_kept", area, exp);
   endtask

   initial begin
      logic [NE*EW-1:0] d;
      logic [NE*EW-1:0] d2;
      logic [AW-1:0]    mx;
      rstn           = 1'b0;
      shape_in_valid = 1'b0;
      shape_in_data  = '0;
      area_ready     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", AW'(shape_in_ready), AW'(0));
      check_eq("rst_area", area, AW'(0));
      check_eq("rst_valid", AW'(area_valid), AW'(0));
`ifdef SHAPE_AREA_DEGENERATE_EN
      check_eq("rst_degenerate", AW'(area_degenerate), AW'(0));
`endif
      rstn = 1'b1;
      #1;
      check_eq("post_rst_in_ready", AW'(shape_in_ready), AW'(1));

      send(pack4(3, 5, 7, 11), AW'(92), 0, 1'b0, '0);
      send(pack4(0, 39'hDEADBEEF, 0, 0), AW'(0), 0, 1'b0, '0);

      mx = (AW'(1) << EW) - AW'(1);
      mx = AW'(2) * mx * mx;
      send(pack4('1, '1, '1, '1), mx, 0, 1'b0, '0);

      d = pack4(9, 8, 7, 6);
      send(d, AW'(114), 5, 1'b0, '0);
      send(pack4(1, 2, 3, 4), AW'(14), 0, 1'b0, '0);

      // Reset during CALC must discard the in-flight record.
      area_ready     = 1'b1;
      shape_in_data  = pack4(100, 200, 300, 400);
      shape_in_valid = 1'b1;
      @(posedge clk); #1;
      shape_in_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      check_eq("midcalc_area", area, AW'(0));
      check_eq("midcalc_valid", AW'(area_valid), AW'(0));
      check_eq("midcalc_in_ready_low", AW'(shape_in_ready), AW'(0));
      rstn = 1'b1;
      #1;
      check_eq("midcalc_in_ready", AW'(shape_in_ready), AW'(1));
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check_eq("no_stale_result", AW'(area_valid), AW'(0));
      end

      // Back-to-back with valid held high across both records.
      d  = pack4(10, 20, 30, 40);
      d2 = pack4(5, 6, 0, 9);
      send(d, AW'(1400), 0, 1'b1, d2);
      send(d2, AW'(30), 0, 1'b0, '0);

      for (int k = 0; k < 25; k++) begin
         d = pack4(rand_elem(), rand_elem(), rand_elem(), rand_elem());
         send(d, ref_area(d), $urandom_range(0, 3), 1'b0, '0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
